// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU request at a time, decodes the CPU opcode
// into one-hot ALU controls, holds the operands for the op's settle time and
// captures the ALU result words into HI/LO. Illegal opcodes and divide-by-zero
// are rejected with a done+error pulse.
//
// Handshake: a request is taken on a rising clock edge where ready=1 and
// start=1. ready is high exactly when the controller is idle, and that includes
// the done cycle, so a new request may follow a completion with no bubble.
// done (and error, for rejected requests) is a single-cycle pulse. start while
// busy is ignored and never queued.
module alu_op_sequencer #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  opcode,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [13:0] alu_ctrl,
   input  logic [31:0] alu_chigh,
   input  logic [31:0] alu_clow,
   output logic [31:0] result_hi,
   output logic [31:0] result_lo
);

   // A zero settle time would make the counter load wrap; refuse to build it.
   if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_param
      $error("alu_op_sequencer: MUL_CYCLES and DIV_CYCLES must be >= 1");
   end

   localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   // alu_ctrl bit positions
   localparam int B_ADD   = 0;
   localparam int B_SUB   = 1;
   localparam int B_MUL   = 2;
   localparam int B_DIV   = 3;
   localparam int B_AND   = 4;
   localparam int B_OR    = 5;
   localparam int B_SHR   = 6;
   localparam int B_SHRA  = 7;
   localparam int B_SHL   = 8;
   localparam int B_ROR   = 9;
   localparam int B_ROL   = 10;
   localparam int B_NEG   = 11;
   localparam int B_NOT   = 12;
   localparam int B_INCPC = 13;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [13:0]   ctrl_q, ctrl_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [13:0]   dec_ctrl;
   logic [CW-1:0] dec_cnt;
   logic          accept_ok;

   // Opcode decode: one-hot control and settle count (L-1) for the request.
   always_comb begin
      dec_ctrl = '0;
      dec_cnt  = '0;
      case (opcode)
         5'b00011: dec_ctrl[B_ADD]   = 1'b1;
         5'b00100: dec_ctrl[B_SUB]   = 1'b1;
         5'b00101: dec_ctrl[B_SHR]   = 1'b1;
         5'b00110: dec_ctrl[B_SHRA]  = 1'b1;
         5'b00111: dec_ctrl[B_SHL]   = 1'b1;
         5'b01000: dec_ctrl[B_ROR]   = 1'b1;
         5'b01001: dec_ctrl[B_ROL]   = 1'b1;
         5'b01010: dec_ctrl[B_AND]   = 1'b1;
         5'b01011: dec_ctrl[B_OR]    = 1'b1;
         5'b01111: begin
            dec_ctrl[B_MUL] = 1'b1;
            dec_cnt         = CW'(MUL_CYCLES - 1);
         end
         5'b10000: begin
            dec_ctrl[B_DIV] = 1'b1;
            dec_cnt         = CW'(DIV_CYCLES - 1);
         end
         5'b10001: dec_ctrl[B_NEG]   = 1'b1;
         5'b10010: dec_ctrl[B_NOT]   = 1'b1;
         5'b11111: dec_ctrl[B_INCPC] = 1'b1;
         default:  dec_ctrl          = '0;
      endcase
   end

   // Legal opcode and no division by zero.
   assign accept_ok = (dec_ctrl != '0) && !(dec_ctrl[B_DIV] && (op_b == '0));

   // Next-state logic: accept/reject in IDLE, count down and capture in EXEC.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (accept_ok) begin
                  a_d     = op_a;
                  b_d     = op_b;
                  ctrl_d  = dec_ctrl;
                  cnt_d   = dec_cnt;
                  state_d = S_EXEC;
               end else begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q == '0) begin
               lo_d = alu_clow;
               // Only MUL/DIV produce a meaningful high word.
               if (ctrl_q[B_MUL] || ctrl_q[B_DIV]) begin
                  hi_d = alu_chigh;
               end
               ctrl_d  = '0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            ctrl_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; clear abandons any in-flight operation.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign busy      = (state_q == S_EXEC);
   assign done      = done_q;
   assign error     = err_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_ctrl  = ctrl_q;
   assign result_hi = hi_q;
   assign result_lo = lo_q;

endmodule
